// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, fetch from a combinational ROM and
// the IF/ID pipeline register. Redirects from downstream win over stalls and
// squash the wrong-path word, so a taken redirect costs exactly one bubble.
module if_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        flush,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_pc4,
   output logic [31:0] if_id_instr,
   output logic        if_id_valid,
   output logic        misalign_err
);

   // Stage contract: if_id_valid=1 marks a real instruction for decode; a
   // bubble carries NOP_INSTR with valid=0. While stall is high the IF/ID
   // contents and the PC are frozen, unless a redirect overrides the stall.
   // All IF/ID outputs come straight from flops; only imem_addr is
   // combinational, and it depends on the PC register alone.

   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [31:0] pc_next;
   logic [31:0] target_aligned;
   logic        target_misaligned;

   assign imem_addr         = {pc[31:2], 2'b00};
   // Wraps naturally at 2^32; no overflow indication is wanted.
   assign pc_plus4          = imem_addr + 32'd4;
   assign target_aligned    = {redirect_target[31:2], 2'b00};
   assign target_misaligned = (redirect_target[1:0] != 2'b00);

   // Next-PC selection: redirect beats stall, stall beats sequential fetch.
   always_comb begin
      pc_next = pc_plus4;
      if (redirect_valid) begin
         pc_next = target_aligned;
      end else if (stall) begin
         pc_next = pc;
      end
   end

   // PC register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= RESET_PC;
      end else begin
         pc <= pc_next;
      end
   end

   // IF/ID register: bubble on flush/redirect (keeping pc/pc4), hold on
   // stall, otherwise capture the word fetched at the current PC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_id_pc    <= 32'h0000_0000;
         if_id_pc4   <= 32'h0000_0000;
         if_id_instr <= NOP_INSTR;
         if_id_valid <= 1'b0;
      end else if (flush || redirect_valid) begin
         if_id_instr <= NOP_INSTR;
         if_id_valid <= 1'b0;
      end else if (!stall) begin
         if_id_pc    <= imem_addr;
         if_id_pc4   <= pc_plus4;
         if_id_instr <= imem_instr;
         if_id_valid <= 1'b1;
      end
   end

   // Sticky misaligned-redirect flag; only reset clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         misalign_err <= 1'b0;
      end else if (redirect_valid && target_misaligned) begin
         misalign_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus a randomized run checked
// against a behavioural model of the fetch stage.
module tb_if_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        flush;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_pc4;
   logic [31:0] if_id_instr;
   logic        if_id_valid;
   logic        misalign_err;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model state
   logic [31:0] m_pc, m_ipc, m_ipc4, m_instr;
   logic        m_valid, m_err;
   logic [31:0] exp_q[$];

   if_stage #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .stall           (stall),
      .flush           (flush),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .imem_addr       (imem_addr),
      .imem_instr      (imem_instr),
      .if_id_pc        (if_id_pc),
      .if_id_pc4       (if_id_pc4),
      .if_id_instr     (if_id_instr),
      .if_id_valid     (if_id_valid),
      .misalign_err    (misalign_err)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction ROM: distinct word per address, fixed word at 0x000.
   function automatic logic [31:0] rom(input logic [31:0] a);
      if (a == 32'h0) return 32'h0000_12B7;
      return (a * 32'h9E37_79B9) ^ 32'h0135_7000;
   endfunction

   assign imem_instr = rom(imem_addr);

   task automatic model_reset();
      m_pc    = 32'h0;
      m_ipc   = 32'h0;
      m_ipc4  = 32'h0;
      m_instr = NOP;
      m_valid = 1'b0;
      m_err   = 1'b0;
   endtask

   // Drive one cycle's inputs, advance the model, step past the edge.
   task automatic cycle(input logic st, input logic fl, input logic rv,
                        input logic [31:0] rt);
      logic [31:0] n_pc;
      stall           = st;
      flush           = fl;
      redirect_valid  = rv;
      redirect_target = rt;
      if (rv)      n_pc = rt & 32'hFFFF_FFFC;
      else if (st) n_pc = m_pc;
      else         n_pc = m_pc + 32'd4;
      if (fl || rv) begin
         m_instr = NOP;
         m_valid = 1'b0;
      end else if (!st) begin
         m_ipc   = m_pc;
         m_ipc4  = m_pc + 32'd4;
         m_instr = rom(m_pc);
         m_valid = 1'b1;
      end
      if (rv && rt[1:0] != 2'b00) m_err = 1'b1;
      m_pc = n_pc;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      stall = 0; flush = 0; redirect_valid = 0; redirect_target = 0;
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      for (int i = 0; i < 5; i++) cycle(0, 0, 0, 32'h0);
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (imem_addr !== 32'h0 || if_id_valid !== 1'b0 || if_id_instr !== NOP ||
          if_id_pc !== 32'h0 || if_id_pc4 !== 32'h0 || misalign_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_async: addr=%h valid=%b instr=%h pc=%h pc4=%h err=%b, want 0/0/%h/0/0/0",
                  imem_addr, if_id_valid, if_id_instr, if_id_pc, if_id_pc4, misalign_err, NOP);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (imem_addr !== 32'h0 || if_id_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_hold: addr=%h valid=%b, want 0/0", imem_addr, if_id_valid);
      end
      rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 32'h0);
      n_checks++;
      if (if_id_pc !== 32'h8 || if_id_pc4 !== 32'hC || imem_addr !== 32'hC) begin
         n_fail++;
         $display("FAIL reset_restart: pc=%h pc4=%h addr=%h, want 8/c/c", if_id_pc, if_id_pc4, imem_addr);
      end
   endtask

   task automatic test_sequential();
      do_reset();
      cycle(0, 0, 0, 32'h0);
      n_checks++;
      if (if_id_instr !== 32'h0000_12B7 || if_id_valid !== 1'b1 || imem_addr !== 32'h4) begin
         n_fail++;
         $display("FAIL seq_first: instr=%h valid=%b addr=%h, want 000012b7/1/4",
                  if_id_instr, if_id_valid, imem_addr);
      end
      cycle(0, 0, 0, 32'h0);
      n_checks++;
      if (if_id_pc !== 32'h4 || if_id_pc4 !== 32'h8 || if_id_instr !== rom(32'h4)) begin
         n_fail++;
         $display("FAIL seq_second: pc=%h pc4=%h instr=%h, want 4/8/%h",
                  if_id_pc, if_id_pc4, if_id_instr, rom(32'h4));
      end
   endtask

   task automatic test_redirect();
      cycle(0, 0, 1, 32'h30);
      // Redirect input must not reach IF/ID outputs before the edge.
      cycle(0, 0, 0, 32'h0);
      redirect_valid  = 1'b1;
      redirect_target = 32'h34;
      #1;
      n_checks++;
      if (if_id_valid !== 1'b1 || if_id_pc !== 32'h30) begin
         n_fail++;
         $display("FAIL redir_comb: valid=%b pc=%h, want 1/30", if_id_valid, if_id_pc);
      end
      @(posedge clk); #1;
      // Rewind: put PC back at 0x030 and redirect from there.
      cycle(0, 0, 1, 32'h30);
      cycle(0, 0, 1, 32'h34);
      n_checks++;
      if (imem_addr !== 32'h34 || if_id_valid !== 1'b0 || if_id_instr !== NOP) begin
         n_fail++;
         $display("FAIL redir_bubble: addr=%h valid=%b instr=%h, want 34/0/%h",
                  imem_addr, if_id_valid, if_id_instr, NOP);
      end
      cycle(0, 0, 0, 32'h0);
      n_checks++;
      if (if_id_pc !== 32'h34 || if_id_valid !== 1'b1 || if_id_instr !== rom(32'h34)) begin
         n_fail++;
         $display("FAIL redir_target: pc=%h valid=%b instr=%h, want 34/1/%h",
                  if_id_pc, if_id_valid, if_id_instr, rom(32'h34));
      end
   endtask

   task automatic test_stall();
      cycle(0, 0, 1, 32'hC);
      cycle(0, 0, 0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         cycle(1, 0, 0, 32'h0);
         n_checks++;
         if (imem_addr !== 32'h10 || if_id_pc !== 32'hC || if_id_pc4 !== 32'h10 ||
             if_id_instr !== rom(32'hC) || if_id_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_hold[%0d]: addr=%h pc=%h pc4=%h instr=%h valid=%b, want 10/c/10/%h/1",
                     i, imem_addr, if_id_pc, if_id_pc4, if_id_instr, if_id_valid, rom(32'hC));
         end
      end
      cycle(1, 0, 1, 32'h48);
      n_checks++;
      if (imem_addr !== 32'h48 || if_id_valid !== 1'b0 || if_id_instr !== NOP || if_id_pc !== 32'hC) begin
         n_fail++;
         $display("FAIL stall_redir: addr=%h valid=%b instr=%h pc=%h, want 48/0/%h/c",
                  imem_addr, if_id_valid, if_id_instr, if_id_pc, NOP);
      end
      cycle(0, 1, 0, 32'h0);
      n_checks++;
      if (imem_addr !== 32'h4C || if_id_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL flush: addr=%h valid=%b, want 4c/0", imem_addr, if_id_valid);
      end
   endtask

   task automatic test_misalign();
      n_checks++;
      if (misalign_err !== 1'b0) begin
         n_fail++;
         $display("FAIL misalign_pre: err=%b, want 0", misalign_err);
      end
      cycle(0, 0, 1, 32'h3A);
      n_checks++;
      if (imem_addr !== 32'h38 || misalign_err !== 1'b1) begin
         n_fail++;
         $display("FAIL misalign_set: addr=%h err=%b, want 38/1", imem_addr, misalign_err);
      end
      cycle(0, 0, 0, 32'h0);
      cycle(0, 0, 1, 32'h100);
      cycle(0, 0, 0, 32'h0);
      n_checks++;
      if (misalign_err !== 1'b1 || if_id_pc !== 32'h100) begin
         n_fail++;
         $display("FAIL misalign_sticky: err=%b pc=%h, want 1/100", misalign_err, if_id_pc);
      end
   endtask

   task automatic test_wrap();
      cycle(0, 0, 1, 32'hFFFF_FFFC);
      n_checks++;
      if (imem_addr !== 32'hFFFF_FFFC) begin
         n_fail++;
         $display("FAIL wrap_addr: addr=%h, want fffffffc", imem_addr);
      end
      cycle(0, 0, 0, 32'h0);
      n_checks++;
      if (imem_addr !== 32'h0 || if_id_pc !== 32'hFFFF_FFFC || if_id_pc4 !== 32'h0 || if_id_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL wrap: addr=%h pc=%h pc4=%h valid=%b, want 0/fffffffc/0/1",
                  imem_addr, if_id_pc, if_id_pc4, if_id_valid);
      end
   endtask

   task automatic test_random();
      int errs;
      logic [31:0] exp_instr;
      errs = 0;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         logic st, fl, rv;
         logic [31:0] rt;
         st = ($urandom_range(0, 3) == 0);
         fl = ($urandom_range(0, 9) == 0);
         rv = ($urandom_range(0, 9) == 0);
         rt = {$urandom_range(0, 32'hFFFF), $urandom_range(0, 32'hFFFF)};
         if ($urandom_range(0, 3) != 0) rt[1:0] = 2'b00;
         cycle(st, fl, rv, rt);
         exp_q.push_back(m_instr);
         exp_instr = exp_q.pop_front();
         n_checks++;
         if (imem_addr !== m_pc || if_id_pc !== m_ipc || if_id_pc4 !== m_ipc4 ||
             if_id_instr !== exp_instr || if_id_valid !== m_valid || misalign_err !== m_err) begin
            n_fail++;
            errs++;
            if (errs < 10)
               $display("FAIL random[%0d]: addr=%h pc=%h pc4=%h instr=%h v=%b err=%b, want %h/%h/%h/%h/%b/%b",
                        i, imem_addr, if_id_pc, if_id_pc4, if_id_instr, if_id_valid, misalign_err,
                        m_pc, m_ipc, m_ipc4, exp_instr, m_valid, m_err);
         end
      end
   endtask

   initial begin
      stall = 0; flush = 0; redirect_valid = 0; redirect_target = 0;
      rst_n = 1'b0;
      model_reset();
      #12;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      test_reset();
      test_sequential();
      test_redirect();
      test_stall();
      test_misalign();
      test_wrap();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013, meaning the bubble encoding (ADDI x0,x0,0).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port stall, input, 1, meaning hold the PC and IF/ID register this cycle.
REQ-006 SHALL have port flush, input, 1, meaning replace the IF/ID contents with a bubble.
REQ-007 SHALL have port redirect_valid, input, 1, meaning a taken branch or jump from downstream.
REQ-008 SHALL have port redirect_target, input, 32, meaning the new PC for a redirect.
REQ-009 SHALL have port imem_addr, output, 32, meaning the byte address driven to the combinational instruction ROM.
REQ-010 SHALL have port imem_instr, input, 32, meaning the instruction word returned by the ROM in the same cycle.
REQ-011 SHALL have port if_id_pc, output, 32, meaning the registered PC of the fetched instruction.
REQ-012 SHALL have port if_id_pc4, output, 32, meaning the registered PC+4 (link value for JAL/JALR).
REQ-013 SHALL have port if_id_instr, output, 32, meaning the registered instruction word.
REQ-014 SHALL have port if_id_valid, output, 1, meaning the IF/ID contents are a real instruction, not a bubble.
REQ-015 SHALL have port misalign_err, output, 1, meaning a sticky flag that a redirect target had bits [1:0] nonzero.

Function
REQ-016 SHALL drive imem_addr combinationally from the PC register, with bits [1:0] always 0.
REQ-017 SHALL compute next PC with priority: redirect_valid -> {redirect_target[31:2],2'b00}; else stall -> hold PC; else PC+4.
REQ-018 SHALL apply a redirect even when stall is asserted in the same cycle.
REQ-019 SHALL compute PC+4 modulo 2^32, so 32'hFFFF_FFFC increments to 32'h0000_0000 without any flag.
REQ-020 SHALL update IF/ID with priority: flush or redirect_valid -> bubble; else stall -> hold; else load {PC, PC+4, imem_instr, valid=1}.
REQ-021 SHALL load a bubble as if_id_instr=NOP_INSTR, if_id_valid=0, with if_id_pc and if_id_pc4 holding their previous values.
REQ-022 SHALL present the instruction fetched at PC p in IF/ID exactly one clock edge after imem_addr=p, giving a latency of 1 cycle.
REQ-023 SHALL incur a taken-redirect penalty of exactly one bubble: the wrong-path word at the old PC never appears with if_id_valid=1.
REQ-024 SHALL set misalign_err on a clock edge when redirect_valid=1 and redirect_target[1:0]!=0; misalign_err clears only on reset.
REQ-025 SHALL keep if_id_instr, if_id_pc and if_id_pc4 bit-stable across consecutive stall cycles.
REQ-026 SHALL have no combinational path from stall, flush or redirect inputs to IF/ID outputs; only imem_addr may change combinationally, and only from PC.

Reset
REQ-027 SHALL, while rst_n=0 and regardless of clk, force PC=RESET_PC, if_id_pc=0, if_id_pc4=0, if_id_instr=NOP_INSTR, if_id_valid=0 and misalign_err=0.
REQ-028 SHALL fetch from RESET_PC on the first rising edge after rst_n deasserts; reset mid-operation discards the IF/ID contents and any pending redirect.

Verification
REQ-029 SHALL verify reset: assert rst_n=0 mid-run -> immediately imem_addr=0x000, if_id_valid=0, if_id_instr=0x00000013; release, then 3 edges -> if_id_pc=0x008, if_id_pc4=0x00C.
REQ-030 SHALL verify sequential fetch: ROM returns 0x000012B7 at 0x000 -> after edge 1, if_id_instr=0x000012B7, if_id_valid=1, imem_addr=0x004.
REQ-031 SHALL verify redirect: at PC=0x030, redirect_valid=1, target=0x034 -> next cycle imem_addr=0x034, if_id_valid=0; following edge if_id_pc=0x034, valid=1.
REQ-032 SHALL verify stall: stall=1 for 3 cycles at PC=0x010 -> imem_addr stays 0x010 and IF/ID unchanged; stall+redirect to 0x048 -> PC=0x048, bubble loaded.
REQ-033 SHALL verify misalignment: redirect target 0x03A -> PC=0x038, misalign_err=1, and the flag stays 1 through later normal redirects.
REQ-034 SHALL verify wrap-around: redirect to 0xFFFFFFFC -> next fetch imem_addr=0x000, if_id_pc4=0x00000000.
